bus_hand_data_top: RTL and testbench
====================================

Name: bus_hand_data_top

Overview:
- Top-level bus-handshake demonstrator with an internal producer/consumer split.
- An ingress stage captures externally valid-qualified words into a small FIFO.
- An internal valid/ready link moves words from the FIFO to a consumer stage. The consumer throttles itself with a fixed, deterministic ready pattern.
- The consumer registers each accepted word onto data_out. The block sits between an unflow-controlled external source and downstream logic that samples data_out.

Parameters:
- width_top, 4, data word width in bits.
- DEPTH, 4, FIFO depth in words (power of two, at least 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- outside_data_valid  input  1  external word qualifier; sampled every rising edge.
- outside_data  input  width_top  external data word.
- data_out  output  width_top  last word accepted by the consumer stage (registered).

Behaviour:
- Reset (rst_n=0, async): FIFO empty, read/write pointers 0, occupancy 0, ready counter 0, data_out=0. No transfer occurs while reset is held. Reset mid-burst discards all buffered words.
- Ingress:
  - At each rising edge with outside_data_valid=1, outside_data is pushed into the FIFO.
  - The push is accepted if the FIFO is not full, or if a pop occurs on the same edge.
  - A word held for N cycles is pushed N times; there is no edge detection.
- Overflow: when the FIFO is full, no pop occurs that edge, and outside_data_valid=1, the word is silently dropped. FIFO contents are unchanged.
- Internal link, producer side:
  - m_valid = (occupancy != 0).
  - m_data = FIFO head. It is combinational from the FIFO registers.
- Internal link, consumer side:
  - A 2-bit free-running counter increments every cycle after reset and wraps 3->0.
  - s_ready = (counter != 3): ready for 3 cycles out of every 4.
  - Right after reset the counter is 0, so ready=1.
- Transfer: occurs on a rising edge where m_valid && s_ready. On that edge:
  - data_out <= m_data.
  - The FIFO pops (read pointer advances).
- Simultaneous push and pop: both take effect and occupancy is unchanged. This holds even when the FIFO is full.
- Empty FIFO: m_valid=0, no transfer, data_out holds its previous value.
- data_out changes only on a transfer edge; otherwise it holds.
- Latency: a word sampled at edge E (FIFO previously empty, s_ready=1 at edge E+1) appears on data_out just after edge E+1. Each stall cycle adds one cycle.
- Ordering: strict FIFO. No duplication beyond repeated pushes; no reordering.
- Pointers: log2(DEPTH) bits, natural wrap. Occupancy counter is log2(DEPTH)+1 bits, range 0..DEPTH.

Test Plan:
- Reset then idle: rst_n low 15 ns, valid=0 -> data_out=0, FIFO empty, no transfers. Assert rst_n low mid-stream -> data_out returns to 0 immediately, asynchronously.
- Single word: valid=1 with data=10 for one cycle, ready high -> data_out=10 one edge after capture, then holds 10 while idle.
- Held word: data=6 with valid for 2 cycles -> two transfers of 6; data_out=6 throughout.
- Sustained burst through stall: words 6,4,8,9,1,15,13, one per cycle, then valid=0.
  - data_out sequence is exactly 6,4,8,9,1,15,13 (no loss, FIFO order).
  - data_out pauses one cycle whenever counter==3.
  - Occupancy never exceeds DEPTH.
- Overflow: force pushes every cycle for >16 cycles (3/4 drain rate, DEPTH=4).
  - Once full, only the expected non-popping-edge words are dropped.
  - The output sequence is the in-order subset of the accepted words.
  - Full-plus-pop edge accepts the incoming word.
- Back-to-back short packets (7 held 2 cycles, gap, 8 one cycle, gap) -> data_out shows 7,7,8 in order, then holds 8 while idle.

Source files
------------

// File: rtl/bus_hand_data_top.sv
// Bus-handshake demonstrator: an ingress FIFO feeds a self-throttling consumer
// over an internal valid/ready link. The consumer registers each accepted word.
module bus_hand_data_top #(
  parameter int width_top = 4,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 outside_data_valid,
  input  logic [width_top-1:0] outside_data,
  output logic [width_top-1:0] data_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [width_top-1:0] mem_r [DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [AW:0]          occ_r;
  logic [1:0]           rdy_cnt_r;
  logic [width_top-1:0] data_out_r;

  logic                 m_valid_s;
  logic [width_top-1:0] m_data_s;
  logic                 s_ready_s;
  logic                 full_s;
  logic                 pop_s;
  logic                 push_s;

  // Internal link handshake and FIFO push/pop decisions.
  always_comb begin
    m_valid_s = 1'b0;
    m_data_s  = mem_r[rd_ptr_r];
    s_ready_s = 1'b0;
    full_s    = 1'b0;
    pop_s     = 1'b0;
    push_s    = 1'b0;
    if (occ_r != {(AW+1){1'b0}}) begin
      m_valid_s = 1'b1;
    end else begin
      m_valid_s = 1'b0;
    end
    if (rdy_cnt_r != 2'd3) begin
      s_ready_s = 1'b1;
    end else begin
      s_ready_s = 1'b0;
    end
    if (occ_r == FULL_LVL) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    pop_s = m_valid_s & s_ready_s;
    // A full FIFO still takes a word when the same edge frees a slot.
    push_s = outside_data_valid & (~full_s | pop_s);
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {width_top{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= outside_data;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Free-running consumer throttle: ready three cycles out of four.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_cnt_r <= 2'd0;
    end else begin
      rdy_cnt_r <= rdy_cnt_r + 2'd1;
    end
  end

  // Consumer output register, updated only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r <= {width_top{1'b0}};
    end else if (pop_s) begin
      data_out_r <= m_data_s;
    end
  end

  assign data_out = data_out_r;

endmodule

// File: tb/tb_bus_hand_data_top.sv
// Scoreboard bench for bus_hand_data_top: a queue-based reference model predicts
// data_out after every edge; a negedge monitor compares against the DUT.
module tb_bus_hand_data_top;

  localparam int W     = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         outside_data_valid = 1'b0;
  logic [W-1:0] outside_data = '0;
  logic [W-1:0] data_out;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_out = '0;
  int           cyc = 0;

  bus_hand_data_top #(.width_top(W), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .outside_data_valid (outside_data_valid),
    .outside_data       (outside_data),
    .data_out           (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    model_out = '0;
    cyc = 0;
  endtask

  // One clock: drive inputs, let the edge happen, predict data_out after it.
  task automatic step(input logic v, input logic [W-1:0] d);
    bit full;
    bit ready;
    bit pop;
    outside_data_valid = v;
    outside_data = d;
    @(posedge clk);
    full  = (fifo_q.size() == DEPTH);
    ready = ((cyc % 4) != 3);
    pop   = (fifo_q.size() != 0) && ready;
    if (pop) model_out = fifo_q.pop_front();
    if (v && (!full || pop)) fifo_q.push_back(d);
    if (fifo_q.size() > DEPTH) begin
      tests++;
      fails++;
      $display("FAIL model_occupancy: got %0d limit %0d", fifo_q.size(), DEPTH);
    end
    cyc++;
    exp_q.push_back(model_out);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  // Monitor: compare each post-edge expectation against the DUT.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() != 0) begin
      chk("data_out", data_out, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    #15;
    chk("reset_data_out", data_out, 4'd0);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    idle(3);
    // Single word
    step(1'b1, 4'd10);
    idle(4);
    // Held word
    step(1'b1, 4'd6);
    step(1'b1, 4'd6);
    idle(4);
    // Sustained burst through a stall
    step(1'b1, 4'd6); step(1'b1, 4'd4); step(1'b1, 4'd8); step(1'b1, 4'd9);
    step(1'b1, 4'd1); step(1'b1, 4'd15); step(1'b1, 4'd13);
    idle(8);
    // Overflow: push every cycle
    for (int i = 0; i < 24; i++) step(1'b1, W'($urandom_range(0, 15)));
    idle(8);
    // Short packets
    step(1'b1, 4'd7); step(1'b1, 4'd7); step(1'b0, 4'd0);
    step(1'b1, 4'd8); step(1'b0, 4'd0);
    idle(5);
    // Random traffic
    for (int i = 0; i < 150; i++) step(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, W'($urandom_range(1, 15)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_data_out", data_out, 4'd0);
    model_reset();
    outside_data_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("held_reset_data_out", data_out, 4'd0);
    rst_n = 1'b1;
    idle(4);
    for (int i = 0; i < 150; i++) step(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
    idle(8);

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
